fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_if.sv | 28 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: instruction memory port, redirect from execute, decode handshake.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; pop_data shows the head and reads as zero when empty.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;
    logic             do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !flush && (count_q == CW'(DEPTH)) && !pop));
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word fetches, queues responses
// in order for decode and discards responses that were in flight across a redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] iq_count;
    logic [CW-1:0] pcq_count;
    logic [31:0]  pcq_head;
    fetch_entry_t iq_head;
    fetch_entry_t iq_push_data;
    logic         credit_ok;
    logic         gnt_fire;
    logic         drop_rsp;
    logic         iq_push;

    // Outstanding fetches plus queued words may never exceed the queue size,
    // so every response has a slot waiting for it.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, iq_count}) < (CW + 1)'(DEPTH);

    assign bus.imem_req  = !rst && !bus.redirect && credit_ok;
    assign bus.imem_addr = pc_q;

    assign gnt_fire     = bus.imem_req && bus.imem_gnt;
    assign drop_rsp     = bus.imem_rvalid && (bus.redirect || (drop_cnt_q != '0));
    assign iq_push      = bus.imem_rvalid && !drop_rsp;
    assign iq_push_data = '{pc: pcq_head, instr: bus.imem_rdata};

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(gnt_fire) - CW'(bus.imem_rvalid);
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc & ~32'h3;
            drop_cnt_d = inflight_q - CW'(bus.imem_rvalid);
        end else begin
            if (gnt_fire) begin
                pc_d = pc_q + 32'(INSTR_BYTES);
            end
            if (bus.imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Addresses of granted fetches; never flushed, dropped responses pop their own entry.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (gnt_fire),
        .push_data (pc_q),
        .pop       (bus.imem_rvalid),
        .pop_data  (pcq_head),
        .count     (pcq_count)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (iq_push),
        .push_data (iq_push_data),
        .pop       (bus.out_ready),
        .pop_data  (iq_head),
        .count     (iq_count)
    );

    assign bus.out_valid = (iq_count != '0);
    assign bus.out_instr = iq_head.instr;
    assign bus.out_pc    = iq_head.pc;

    always @(posedge clk) begin
        if (!rst) begin
            assert (pcq_count == inflight_q);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with optional response hold,
// hand-computed expectations checked with immediate assertions.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_hold;
    logic [31:0] pend [$];
    int          checks   = 0;
    int          failures = 0;

    fetch_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Grants are sampled mid-cycle and answered in order from the following cycle on.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.imem_req && bus.imem_gnt) pend.push_back(bus.imem_addr);
        end
    end

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_hold && pend.size() > 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = instr_of(pend.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'h0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_gnt    = 1'b0;
        bus.out_ready   = 1'b0;
        mem_hold        = 1'b0;
        pend.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        mem_hold        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_gnt    = 1'b0;
        bus.out_ready   = 1'b0;
        #1;
        check("rst_req",       bus.imem_req,  32'h0);
        check("rst_valid",     bus.out_valid, 32'h0);
        check("rst_addr",      bus.imem_addr, 32'h0);
        check("rst_out_pc",    bus.out_pc,    32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);

        // streaming with immediate grants and one-cycle responses
        do_reset();
        bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
        #2; check("s1_c0_req", bus.imem_req, 32'h1); check("s1_c0_addr", bus.imem_addr, 32'h0);
        check("s1_c0_valid", bus.out_valid, 32'h0);
        tick(); #2;
        check("s1_c1_addr", bus.imem_addr, 32'h4); check("s1_c1_valid", bus.out_valid, 32'h0);
        tick(); #2;
        check("s1_c2_req", bus.imem_req, 32'h0); check("s1_c2_valid", bus.out_valid, 32'h1);
        check("s1_c2_pc", bus.out_pc, 32'h0); check("s1_c2_instr", bus.out_instr, instr_of(32'h0));
        tick(); #2;
        check("s1_c3_addr", bus.imem_addr, 32'h8); check("s1_c3_req", bus.imem_req, 32'h1);
        check("s1_c3_pc", bus.out_pc, 32'h4); check("s1_c3_instr", bus.out_instr, instr_of(32'h4));
        tick(); #2;
        check("s1_c4_addr", bus.imem_addr, 32'hC); check("s1_c4_valid", bus.out_valid, 32'h0);
        tick(); #2;
        check("s1_c5_pc", bus.out_pc, 32'h8); check("s1_c5_instr", bus.out_instr, instr_of(32'h8));

        // decode stalled: credit stops requests after two grants
        do_reset();
        bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
        #2; check("s2_c0_addr", bus.imem_addr, 32'h0);
        tick(); #2; check("s2_c1_addr", bus.imem_addr, 32'h4);
        tick(); #2;
        check("s2_c2_req", bus.imem_req, 32'h0); check("s2_c2_pc", bus.out_pc, 32'h0);
        check("s2_c2_addr", bus.imem_addr, 32'h8);
        tick(); #2;
        check("s2_c3_req", bus.imem_req, 32'h0); check("s2_c3_pc", bus.out_pc, 32'h0);
        check("s2_c3_instr", bus.out_instr, instr_of(32'h0));
        tick(); bus.out_ready = 1'b1; #2;
        check("s2_c4_req", bus.imem_req, 32'h0); check("s2_c4_valid", bus.out_valid, 32'h1);
        tick(); #2;
        check("s2_c5_req", bus.imem_req, 32'h1); check("s2_c5_addr", bus.imem_addr, 32'h8);
        check("s2_c5_pc", bus.out_pc, 32'h4);

        // grant withheld: address held
        do_reset();
        bus.out_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h10;
        #2; check("s3_redir_req", bus.imem_req, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(); bus.redirect = 1'b0; #2;
            check("s3_hold_req", bus.imem_req, 32'h1); check("s3_hold_addr", bus.imem_addr, 32'h10);
        end
        tick(); bus.imem_gnt = 1'b1; #2; check("s3_gnt_addr", bus.imem_addr, 32'h10);
        tick(); bus.imem_gnt = 1'b0; #2; check("s3_next_addr", bus.imem_addr, 32'h14);
        tick(); #2;
        check("s3_out_pc", bus.out_pc, 32'h10); check("s3_out_instr", bus.out_instr, instr_of(32'h10));
        check("s3_addr_after", bus.imem_addr, 32'h14);

        // two fetches in flight dropped by a redirect to an unaligned pc
        do_reset();
        bus.out_ready = 1'b1; mem_hold = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h20;
        tick(); bus.redirect = 1'b0; bus.imem_gnt = 1'b1; #2;
        check("s4_c1_addr", bus.imem_addr, 32'h20);
        tick(); #2; check("s4_c2_addr", bus.imem_addr, 32'h24);
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h103; #2;
        check("s4_c3_req", bus.imem_req, 32'h0);
        tick(); bus.redirect = 1'b0; mem_hold = 1'b0; #2;
        check("s4_c4_req", bus.imem_req, 32'h0); check("s4_c4_addr", bus.imem_addr, 32'h100);
        tick(); #2;
        check("s4_c5_req", bus.imem_req, 32'h1); check("s4_c5_valid", bus.out_valid, 32'h0);
        tick(); #2;
        check("s4_c6_valid", bus.out_valid, 32'h0); check("s4_c6_addr", bus.imem_addr, 32'h104);
        tick(); #2;
        check("s4_c7_pc", bus.out_pc, 32'h100); check("s4_c7_instr", bus.out_instr, instr_of(32'h100));

        // redirect with a response and an output handshake in the same cycle
        do_reset();
        bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
        tick(); tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h300; #2;
        check("s5a_c2_valid", bus.out_valid, 32'h1); check("s5a_c2_req", bus.imem_req, 32'h0);
        tick(); bus.redirect = 1'b0; #2;
        check("s5a_c3_valid", bus.out_valid, 32'h0); check("s5a_c3_addr", bus.imem_addr, 32'h300);
        tick(); #2; check("s5a_c4_valid", bus.out_valid, 32'h0);
        tick(); #2; check("s5a_c5_pc", bus.out_pc, 32'h300);

        // redirect coincident with a response while another is still outstanding
        do_reset();
        bus.imem_gnt = 1'b1; bus.out_ready = 1'b1; mem_hold = 1'b1;
        tick(); tick(); mem_hold = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h200; #2;
        check("s5b_c2_req", bus.imem_req, 32'h0);
        tick(); bus.redirect = 1'b0; #2;
        check("s5b_c3_valid", bus.out_valid, 32'h0); check("s5b_c3_addr", bus.imem_addr, 32'h200);
        tick(); #2;
        check("s5b_c4_valid", bus.out_valid, 32'h0); check("s5b_c4_addr", bus.imem_addr, 32'h204);
        tick(); #2;
        check("s5b_c5_pc", bus.out_pc, 32'h200); check("s5b_c5_instr", bus.out_instr, instr_of(32'h200));

        // pc wrap, then asynchronous reset mid-cycle
        do_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        tick(); bus.redirect = 1'b0; bus.imem_gnt = 1'b1; #2;
        check("s6_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick(); #2; check("s6_wrap_addr", bus.imem_addr, 32'h0);
        tick(); #2;
        check("s6_out_pc", bus.out_pc, 32'hFFFF_FFFC); check("s6_addr4", bus.imem_addr, 32'h4);
        #1; rst = 1'b1; #1;
        check("s6_arst_valid", bus.out_valid, 32'h0); check("s6_arst_req", bus.imem_req, 32'h0);
        check("s6_arst_addr", bus.imem_addr, 32'h0); check("s6_arst_pc", bus.out_pc, 32'h0);
        pend.delete();
        tick(); rst = 1'b0; #2;
        check("s6_release_req", bus.imem_req, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
